mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port req_valid, input, 1 bit: the pipeline presents a load/store request.
REQ-004 The block SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-005 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 The block SHALL have port req_signed, input, 1 bit: sign-extend sub-word loads when 1.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port resp_rdata, output, 32 bits: extended load result, 0 for stores.
REQ-012 The block SHALL have port resp_err, output, 1 bit: the request was rejected; valid with resp_valid.
REQ-013 The block SHALL have ports mem_addr (output, 32 bits), mem_wdata (output, 32 bits), mem_memwrite (output, 1 bit) and mem_memread (output, 1 bit) driving the word-indexed data memory.
REQ-014 The block SHALL have port mem_read_data, input, 32 bits: memory output, registered, valid the cycle after the edge that sampled mem_memread.

Function
REQ-015 The block SHALL implement the states IDLE, READ, WAIT, WRITE and RESP, with all outputs driven from registers.
REQ-016 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted at a rising edge with req_valid=1 and req_ready=1.
REQ-017 On acceptance, the block SHALL capture all request fields; the inputs need not stay stable afterwards.
REQ-018 mem_addr SHALL equal {2'b00, addr[31:2]} of the captured address in every non-IDLE state, and 0 in IDLE.
REQ-019 A word store SHALL transition IDLE -> WRITE (mem_memwrite=1, mem_wdata=wdata) -> RESP, so resp_valid is high in the 2nd cycle after acceptance.
REQ-020 A load SHALL transition IDLE -> READ (mem_memread=1) -> WAIT (mem_read_data captured at the end of WAIT) -> RESP, so resp_valid is high in the 3rd cycle after acceptance.
REQ-021 A byte or halfword store SHALL perform a read-modify-write: IDLE -> READ -> WAIT -> WRITE (merged word) -> RESP.
REQ-022 The merge SHALL replace only lane addr[1:0] (byte) or lane addr[1] (halfword) with the low bits of wdata and keep the other bytes unchanged.
REQ-023 Load extraction SHALL select the byte or halfword lane and zero-extend it, or sign-extend it when req_signed=1; a word load SHALL return the word unchanged.
REQ-024 mem_memread and mem_memwrite SHALL never be 1 in the same cycle, and each SHALL be high for exactly one cycle per access.
REQ-025 RESP SHALL last one cycle and then return to IDLE, so back-to-back requests are accepted every RESP+1 cycle.
REQ-026 For req_size=11, the block SHALL go IDLE -> RESP with resp_err=1 and make no memory access.

Reset
REQ-027 When rst_n=0, the block SHALL immediately force state IDLE and set req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_memread=0 and mem_memwrite=0.
REQ-028 Reset mid-operation SHALL abandon the access with no response; a WRITE cut by reset SHALL deassert mem_memwrite asynchronously.
REQ-029 req_ready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-030 With MEM_ACCESS_ALIGN_CHECK_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL go IDLE -> RESP with resp_err=1 and make no memory access.
REQ-031 Without MEM_ACCESS_ALIGN_CHECK_EN, low address bits below the access size SHALL be ignored (a halfword uses lane addr[1], a word uses the full word), and resp_err SHALL be set only for req_size=11.

Verification
REQ-032 The bench SHALL check: word store addr 0x10, data 0xDEADBEEF -> mem_memwrite pulse with mem_addr=4; a word load at 0x10 then returns 0xDEADBEEF with resp_valid 3 cycles after acceptance.
REQ-033 The bench SHALL check: byte store 0xA5 at 0x11 over word 0x11223344 -> memory word becomes 0x1122A544, with exactly one read and one write.
REQ-034 The bench SHALL check: a signed byte load at 0x11 of 0x1122A544 -> resp_rdata=0xFFFFFFA5; the same load unsigned -> 0x000000A5.
REQ-035 The bench SHALL check: a halfword signed load at 0x12 of 0x8001A544 -> 0xFFFF8001.
REQ-036 The bench SHALL check, with MEM_ACCESS_ALIGN_CHECK_EN defined: word load at 0x13 -> resp_err=1 one cycle after acceptance, with mem_memread never asserted.
REQ-037 The bench SHALL check: rst_n=0 asserted during WRITE -> mem_memwrite=0 immediately, no resp_valid, and req_ready=1 one cycle after reset release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: sequences word, sub-word (read-modify-write) and illegal accesses onto a word-indexed data memory.
// Optional build macro MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with resp_err.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_memwrite_q, mem_memwrite_d;
    logic        mem_memread_q, mem_memread_d;

    logic        accept_s;
    logic        bad_s;

    // Replace the addressed byte/halfword lane of old_word with the low bits of wdata.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word, input logic [31:0] wdata,
                                               input logic [1:0] addr_lo, input logic [1:0] size);
        logic [31:0] w;
        w = old_word;
        case (size)
            2'b00:   w[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            2'b01:   w[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    // Select the addressed lane of word and zero- or sign-extend it to 32 bits.
    function automatic logic [31:0] extract_word(input logic [31:0] word, input logic [1:0] addr_lo,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
            2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Request rejection: illegal size always, misalignment only when the check is built in.
    always_comb begin
        bad_s = (req_size == 2'b11);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if (req_size == 2'b01 && req_addr[0]) begin
            bad_s = 1'b1;
        end else if (req_size == 2'b10 && req_addr[1:0] != 2'b00) begin
            bad_s = 1'b1;
        end else begin
            bad_s = (req_size == 2'b11);
        end
`endif
    end

    // State register and captured request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic; sub-word stores detour through READ/WAIT to fetch the word being merged.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    accept_s = 1'b1;
                    write_d  = req_write;
                    size_d   = req_size;
                    sgn_d    = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (bad_s) begin
                        state_d = ST_RESP;
                    end else if (req_write && req_size == 2'b10) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT:  state_d = write_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered.
    always_comb begin
        req_ready_d    = (state_d == ST_IDLE);
        resp_valid_d   = (state_d == ST_RESP);
        resp_err_d     = accept_s && bad_s;
        mem_memread_d  = (state_d == ST_READ);
        mem_memwrite_d = (state_d == ST_WRITE);
        mem_addr_d     = (state_d != ST_IDLE) ? {2'b00, addr_d[31:2]} : 32'h0000_0000;
        mem_wdata_d    = 32'h0000_0000;
        resp_rdata_d   = 32'h0000_0000;
        if (state_d == ST_WRITE) begin
            if (state_q == ST_WAIT) begin
                mem_wdata_d = merge_word(mem_read_data, wdata_q, addr_q[1:0], size_q);
            end else begin
                mem_wdata_d = wdata_d;
            end
        end else begin
            mem_wdata_d = 32'h0000_0000;
        end
        if (state_q == ST_WAIT && !write_q) begin
            resp_rdata_d = extract_word(mem_read_data, addr_q[1:0], size_q, sgn_q);
        end else begin
            resp_rdata_d = 32'h0000_0000;
        end
    end

    // Output registers; reset drops every strobe asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'h0000_0000;
            resp_err_q     <= 1'b0;
            mem_addr_q     <= 32'h0000_0000;
            mem_wdata_q    <= 32'h0000_0000;
            mem_memwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
        end else begin
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_memwrite_q <= mem_memwrite_d;
            mem_memread_q  <= mem_memread_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_memwrite = mem_memwrite_q;
    assign mem_memread  = mem_memread_q;

endmodule
